// File: rtl/guitar_effect_mc.sv
`default_nettype none
// ============================================================================
// Module   : guitar_effect_mc
// Purpose  : Multi-channel distortion effect with per-channel gain and
//            clipping, streamed I/O and an Avalon-MM register slave.
// Revision : 1.0 - initial release
// ============================================================================
module guitar_effect_mc #(
    parameter int DATA_W    = 16,
    parameter int CHANNELS  = 2,
    parameter int GAIN_W    = 8,
    parameter int GAIN_FRAC = 4
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [4:0]                                     avl_address,
    input  logic                                           avl_read,
    input  logic                                           avl_write,
    input  logic [31:0]                                    avl_writedata,
    output logic [31:0]                                    avl_readdata,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] in_channel,
    input  logic [DATA_W-1:0]                              in_data,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_channel,
    output logic [DATA_W-1:0]                              out_data
);
    localparam int c_ch_w = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_p_w  = DATA_W + GAIN_W;

    localparam logic [4:0] c_addr_ctrl   = 5'h00;
    localparam logic [4:0] c_addr_status = 5'h03;
    localparam logic [4:0] c_addr_scnt   = 5'h04;
    localparam logic [1:0] c_mode_bypass = 2'b00;
    localparam logic [1:0] c_mode_asym   = 2'b10;

    localparam logic [GAIN_W-1:0]        c_gain_one  = GAIN_W'(1) << GAIN_FRAC;
    localparam logic [DATA_W-2:0]        c_boost_rst = '1;
    localparam logic signed [c_p_w-1:0]  c_sat_max   = {{(GAIN_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [c_p_w-1:0]  c_sat_min   = {{(GAIN_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic                     r_enable_q, w_enable_d;
    logic [1:0]               r_mode_q, w_mode_d;
    logic [GAIN_W-1:0]        r_gain_q  [CHANNELS];
    logic [GAIN_W-1:0]        w_gain_d  [CHANNELS];
    logic [DATA_W-2:0]        r_boost_q [CHANNELS];
    logic [DATA_W-2:0]        w_boost_d [CHANNELS];
    logic [15:0]              r_clip_cnt_q, w_clip_cnt_d;
    logic [31:0]              r_sample_cnt_q, w_sample_cnt_d;
    logic [31:0]              r_rdata_q, w_rdata_d, w_rdata;

    logic                     r_s1_valid_q, w_s1_valid_d;
    logic signed [c_p_w-1:0]  r_s1_val_q, w_s1_val_d;
    logic [1:0]               r_s1_mode_q, w_s1_mode_d;
    logic [DATA_W-2:0]        r_s1_thr_q, w_s1_thr_d;
    logic [c_ch_w-1:0]        r_s1_ch_q, w_s1_ch_d;
    logic                     r_out_valid_q, w_out_valid_d;
    logic [DATA_W-1:0]        r_out_data_q, w_out_data_d;
    logic [c_ch_w-1:0]        r_out_ch_q, w_out_ch_d;

    logic                     w_stall, w_accept, w_busy, w_is_chreg, w_status_clr, w_clip;
    logic [1:0]               w_ch_sel;
    logic [GAIN_W-1:0]        w_ch_gain;
    logic [DATA_W-2:0]        w_ch_boost, w_lo_mag;
    logic signed [c_p_w-1:0]  w_din_ext, w_gain_ext, w_prod, w_scaled;
    logic signed [c_p_w-1:0]  w_hi, w_lo_ext, w_lo, w_lim, w_sat;
    logic                     w_unused;

    assign w_stall      = r_out_valid_q && !out_ready;
    assign in_ready     = r_enable_q && !w_stall;
    assign w_accept     = in_valid && in_ready;
    assign w_busy       = r_s1_valid_q || r_out_valid_q;
    assign w_is_chreg   = (avl_address[4:3] == 2'b01);
    assign w_ch_sel     = avl_address[2:1];
    assign w_status_clr = avl_write && (avl_address == c_addr_status) && avl_writedata[0];

    // Stage 1: per-channel gain and snapshot of the settings that govern this sample
    always_comb begin
        w_ch_gain  = r_gain_q[0];
        w_ch_boost = r_boost_q[0];
        for (int c = 0; c < CHANNELS; c++) begin
            if (in_channel == c_ch_w'(c)) begin
                w_ch_gain  = r_gain_q[c];
                w_ch_boost = r_boost_q[c];
            end
        end
        w_din_ext  = {{GAIN_W{in_data[DATA_W-1]}}, in_data};
        w_gain_ext = {{DATA_W{1'b0}}, w_ch_gain};
        w_prod     = w_din_ext * w_gain_ext;
        w_scaled   = w_prod >>> GAIN_FRAC;

        w_s1_valid_d = r_s1_valid_q;
        w_s1_val_d   = r_s1_val_q;
        w_s1_mode_d  = r_s1_mode_q;
        w_s1_thr_d   = r_s1_thr_q;
        w_s1_ch_d    = r_s1_ch_q;
        if (!w_stall) begin
            w_s1_valid_d = w_accept;
            if (w_accept) begin
                w_s1_val_d  = (r_mode_q == c_mode_bypass) ? w_din_ext : w_scaled;
                w_s1_mode_d = r_mode_q;
                w_s1_thr_d  = w_ch_boost;
                w_s1_ch_d   = in_channel;
            end
        end
    end

    // Stage 2: mode-dependent limit, then saturation to the sample range
    always_comb begin
        w_hi     = {{(GAIN_W+1){1'b0}}, r_s1_thr_q};
        w_lo_mag = (r_s1_mode_q == c_mode_asym) ? (r_s1_thr_q >> 1) : r_s1_thr_q;
        w_lo_ext = {{(GAIN_W+1){1'b0}}, w_lo_mag};
        w_lo     = -w_lo_ext;
        w_lim    = r_s1_val_q;
        if (r_s1_mode_q != c_mode_bypass) begin
            if (r_s1_val_q > w_hi) begin
                w_lim = w_hi;
            end else if (r_s1_val_q < w_lo) begin
                w_lim = w_lo;
            end
        end
        w_sat = w_lim;
        if (w_lim > c_sat_max) begin
            w_sat = c_sat_max;
        end else if (w_lim < c_sat_min) begin
            w_sat = c_sat_min;
        end
        w_clip = (w_sat != r_s1_val_q);

        w_out_valid_d = r_out_valid_q;
        w_out_data_d  = r_out_data_q;
        w_out_ch_d    = r_out_ch_q;
        if (!w_stall) begin
            w_out_valid_d = r_s1_valid_q;
            if (r_s1_valid_q) begin
                w_out_data_d = w_sat[DATA_W-1:0];
                w_out_ch_d   = r_s1_ch_q;
            end
        end
    end

    always_comb begin
        w_enable_d     = r_enable_q;
        w_mode_d       = r_mode_q;
        w_gain_d       = r_gain_q;
        w_boost_d      = r_boost_q;
        w_rdata        = '0;
        w_clip_cnt_d   = r_clip_cnt_q;
        w_sample_cnt_d = r_sample_cnt_q;

        if (avl_write && (avl_address == c_addr_ctrl)) begin
            w_enable_d = avl_writedata[0];
            w_mode_d   = avl_writedata[2:1];
        end
        case (avl_address)
            c_addr_ctrl:   w_rdata = {29'd0, r_mode_q, r_enable_q};
            c_addr_status: w_rdata = {w_busy, 15'd0, r_clip_cnt_q};
            c_addr_scnt:   w_rdata = r_sample_cnt_q;
            default:       w_rdata = '0;
        endcase
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_is_chreg && (w_ch_sel == 2'(c))) begin
                if (!avl_address[0]) begin
                    w_rdata = {{(32-GAIN_W){1'b0}}, r_gain_q[c]};
                    if (avl_write) w_gain_d[c] = avl_writedata[GAIN_W-1:0];
                end else begin
                    w_rdata = {{(33-DATA_W){1'b0}}, r_boost_q[c]};
                    if (avl_write) w_boost_d[c] = avl_writedata[DATA_W-2:0];
                end
            end
        end
        w_rdata_d = avl_read ? w_rdata : r_rdata_q;

        if (w_status_clr) begin
            w_clip_cnt_d = '0;
        end else if (!w_stall && r_s1_valid_q && w_clip && (r_clip_cnt_q != 16'hFFFF)) begin
            w_clip_cnt_d = r_clip_cnt_q + 16'd1;
        end
        if (avl_write && (avl_address == c_addr_scnt)) begin
            w_sample_cnt_d = '0;
        end else if (r_out_valid_q && out_ready) begin
            w_sample_cnt_d = r_sample_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable_q     <= 1'b1;
            r_mode_q       <= 2'b01;
            for (int c = 0; c < CHANNELS; c++) begin
                r_gain_q[c]  <= c_gain_one;
                r_boost_q[c] <= c_boost_rst;
            end
            r_clip_cnt_q   <= '0;
            r_sample_cnt_q <= '0;
            r_rdata_q      <= '0;
            r_s1_valid_q   <= 1'b0;
            r_s1_val_q     <= '0;
            r_s1_mode_q    <= '0;
            r_s1_thr_q     <= '0;
            r_s1_ch_q      <= '0;
            r_out_valid_q  <= 1'b0;
            r_out_data_q   <= '0;
            r_out_ch_q     <= '0;
        end else begin
            r_enable_q     <= w_enable_d;
            r_mode_q       <= w_mode_d;
            r_gain_q       <= w_gain_d;
            r_boost_q      <= w_boost_d;
            r_clip_cnt_q   <= w_clip_cnt_d;
            r_sample_cnt_q <= w_sample_cnt_d;
            r_rdata_q      <= w_rdata_d;
            r_s1_valid_q   <= w_s1_valid_d;
            r_s1_val_q     <= w_s1_val_d;
            r_s1_mode_q    <= w_s1_mode_d;
            r_s1_thr_q     <= w_s1_thr_d;
            r_s1_ch_q      <= w_s1_ch_d;
            r_out_valid_q  <= w_out_valid_d;
            r_out_data_q   <= w_out_data_d;
            r_out_ch_q     <= w_out_ch_d;
        end
    end

    assign avl_readdata = r_rdata_q;
    assign out_valid    = r_out_valid_q;
    assign out_data     = r_out_data_q;
    assign out_channel  = r_out_ch_q;
    assign w_unused     = ^{avl_writedata, w_sat[c_p_w-1:DATA_W]};

endmodule
`default_nettype wire

// File: tb/tb_guitar_effect_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_guitar_effect_mc
// Purpose  : Self-checking bench for guitar_effect_mc (vector table plus
//            directed multi-cycle sequences, scoreboarded output stream).
// Revision : 1.0 - initial release
// ============================================================================
module tb_guitar_effect_mc;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  avl_address = '0;
    logic        avl_read = 1'b0;
    logic        avl_write = 1'b0;
    logic [31:0] avl_writedata = '0;
    logic [31:0] avl_readdata;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [0:0]  in_channel = '0;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [0:0]  out_channel;
    logic [15:0] out_data;

    always #5 clk = ~clk;

    guitar_effect_mc #(.DATA_W(16), .CHANNELS(2), .GAIN_W(8), .GAIN_FRAC(4)) dut (
        .clk(clk), .reset(reset),
        .avl_address(avl_address), .avl_read(avl_read), .avl_write(avl_write),
        .avl_writedata(avl_writedata), .avl_readdata(avl_readdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_channel(in_channel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel), .out_data(out_data)
    );

    typedef struct { logic ch; logic [15:0] data; } exp_t;
    typedef struct { logic [2:0] ctrl; logic ch; logic [15:0] din; logic [15:0] dout; int clip; } vec_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_ch = 1'b0;
    exp_t        mon_e;

    // Output monitor: scoreboard pops, stall stability and in_ready during stall
    always @(negedge clk) begin
        if (prev_stall && reset === 1'b0) begin
            n_cmp++;
            if (out_data !== prev_data || out_channel !== prev_ch) begin
                n_fail++;
                $display("FAIL stall_hold: got ch=%0d data=0x%04h, required ch=%0d data=0x%04h",
                         out_channel, out_data, prev_ch, prev_data);
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b0) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL in_ready_stall: got %b, required 0", in_ready);
            end
        end
        prev_stall = (out_valid === 1'b1 && out_ready === 1'b0);
        prev_data  = out_data;
        prev_ch    = out_channel;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got ch=%0d data=%0d, required no output",
                         out_channel, $signed(out_data));
            end else begin
                mon_e = sb.pop_front();
                if (out_data !== mon_e.data || out_channel !== mon_e.ch) begin
                    n_fail++;
                    $display("FAIL stream_out: got ch=%0d data=%0d, required ch=%0d data=%0d",
                             out_channel, $signed(out_data), mon_e.ch, $signed(mon_e.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        avl_address = a; avl_writedata = d; avl_write = 1'b1;
        tick();
        avl_write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        avl_address = a; avl_read = 1'b1;
        tick();
        avl_read = 1'b0;
        d = avl_readdata;
    endtask

    task automatic rd_check(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    task automatic send(input logic ch, input logic [15:0] d, input logic [15:0] e);
        bit   ok;
        int   guard;
        exp_t x;
        ok = 1'b0; guard = 0;
        in_valid = 1'b1; in_channel = ch; in_data = d;
        while (!ok && guard < 50) begin
            @(negedge clk);
            ok = (in_ready === 1'b1);
            tick();
            guard++;
        end
        in_valid = 1'b0;
        if (ok) begin
            x.ch = ch; x.data = e;
            sb.push_back(x);
        end else begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles, required accept");
        end
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while (sb.size() != 0 && g < 100) begin
            tick();
            g++;
        end
        repeat (2) tick();
        check(name, 32'(sb.size()), 32'd0);
    endtask

    vec_t vecs[15];

    initial begin
        int exp_clips;
        vecs[0]  = '{3'h3, 1'b1, 16'd5000,    16'd4000,    1};
        vecs[1]  = '{3'h3, 1'b1, -16'sd5000,  -16'sd4000,  1};
        vecs[2]  = '{3'h3, 1'b1, 16'd3999,    16'd3999,    0};
        vecs[3]  = '{3'h3, 1'b1, 16'd4000,    16'd4000,    0};
        vecs[4]  = '{3'h3, 1'b1, -16'sd4000,  -16'sd4000,  0};
        vecs[5]  = '{3'h5, 1'b1, -16'sd5000,  -16'sd2000,  1};
        vecs[6]  = '{3'h5, 1'b1, -16'sd2000,  -16'sd2000,  0};
        vecs[7]  = '{3'h5, 1'b1, -16'sd2001,  -16'sd2000,  1};
        vecs[8]  = '{3'h5, 1'b1, 16'd5000,    16'd4000,    1};
        vecs[9]  = '{3'h1, 1'b1, 16'd5000,    16'd5000,    0};
        vecs[10] = '{3'h1, 1'b0, 16'd1000,    16'd1000,    0};
        vecs[11] = '{3'h7, 1'b1, -16'sd4500,  -16'sd4000,  1};
        vecs[12] = '{3'h3, 1'b0, -16'sd1000,  -16'sd2000,  0};
        vecs[13] = '{3'h3, 1'b0, 16'd20000,   16'h7FFF,    1};
        vecs[14] = '{3'h3, 1'b0, -16'sd20000, -16'sd32767, 1};

        // Reset state and register map
        repeat (2) tick();
        reset = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_readdata", avl_readdata, 32'd0);
        rd_check("rst_ctrl", 5'h00, 32'h3);
        rd_check("rst_gain0", 5'h08, 32'h10);
        rd_check("rst_boost0", 5'h09, 32'h7FFF);
        tick();
        check("readdata_hold", avl_readdata, 32'h7FFF);
        rd_check("rst_gain1", 5'h0A, 32'h10);
        rd_check("rst_boost1", 5'h0B, 32'h7FFF);
        rd_check("rst_status", 5'h03, 32'h0);
        rd_check("rst_scnt", 5'h04, 32'h0);
        wr(5'h0C, 32'h55);
        rd_check("unmapped_ch2", 5'h0C, 32'h0);
        rd_check("unmapped_01", 5'h01, 32'h0);
        wr(5'h08, 32'hFFFF_FF20);
        rd_check("gain_field_mask", 5'h08, 32'h20);

        // Gain path with latency check
        send(1'b0, 16'd1000, 16'd2000);
        @(negedge clk);
        check("latency_c1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("latency_c2", {31'd0, out_valid}, 32'd1);
        check("gain_data", {16'd0, out_data}, 32'd2000);
        tick();
        drain("drain_gain");
        rd_check("gain_clip_cnt", 5'h03, 32'h0);

        // Vector table
        wr(5'h0B, 32'd4000);
        exp_clips = 0;
        for (int i = 0; i < 15; i++) begin
            wr(5'h00, {29'd0, vecs[i].ctrl});
            send(vecs[i].ch, vecs[i].din, vecs[i].dout);
            exp_clips += vecs[i].clip;
        end
        drain("drain_table");
        rd_check("table_clip_cnt", 5'h03, 32'(exp_clips));
        wr(5'h03, 32'h1);
        rd_check("status_clear", 5'h03, 32'h0);

        // Saturation at high gain, asymmetric mode
        wr(5'h00, 32'h5);
        wr(5'h08, 32'hFF);
        send(1'b0, 16'h7000, 16'h7FFF);
        send(1'b0, -16'sh7000, -16'sd16383);
        drain("drain_sat");
        rd_check("sat_clip_cnt", 5'h03, 32'h2);

        // Arithmetic shift of negative products
        wr(5'h00, 32'h3);
        wr(5'h08, 32'h18);
        send(1'b0, -16'sd3, -16'sd5);
        send(1'b0, 16'd3, 16'd4);
        drain("drain_shift");

        // ENABLE=0 drains the pipeline and blocks input
        wr(5'h08, 32'h10);
        send(1'b0, 16'd123, 16'd123);
        wr(5'h00, 32'h2);
        check("disable_in_ready", {31'd0, in_ready}, 32'd0);
        drain("drain_disable");
        wr(5'h00, 32'h3);
        check("enable_in_ready", {31'd0, in_ready}, 32'd1);

        // Backpressure: 6 back-to-back samples with a 3-cycle stall
        wr(5'h04, 32'h0);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [15:0] v;
                    v = (i % 2 == 1) ? 16'(-300 * (i + 1)) : 16'(300 * (i + 1));
                    send(1'(i % 2), v, v);
                end
            end
            begin
                repeat (2) tick();
                out_ready = 1'b0;
                repeat (3) tick();
                out_ready = 1'b1;
            end
        join
        drain("drain_bp");
        rd_check("bp_sample_cnt", 5'h04, 32'd6);

        // Same-cycle read and write returns the old value
        avl_address = 5'h08; avl_writedata = 32'h30; avl_read = 1'b1; avl_write = 1'b1;
        tick();
        avl_read = 1'b0; avl_write = 1'b0;
        check("rd_wr_same_old", avl_readdata, 32'h10);
        rd_check("rd_wr_same_new", 5'h08, 32'h30);

        // Gain write while a sample is in stage 1
        wr(5'h08, 32'h10);
        send(1'b0, 16'd1000, 16'd1000);
        wr(5'h08, 32'h30);
        send(1'b0, 16'd1000, 16'd3000);
        drain("drain_midgain");

        // STATUS clear coinciding with a clip event
        send(1'b1, 16'd5000, 16'd4000);
        wr(5'h03, 32'h1);
        drain("drain_clrclip");
        rd_check("clear_wins", 5'h03, 32'h0);

        // Reset with samples in flight
        out_ready = 1'b0;
        send(1'b0, 16'd10, 16'd10);
        send(1'b1, 16'd20, 16'd20);
        rd_check("busy_before_reset", 5'h03, 32'h8000_0000);
        reset = 1'b1;
        tick();
        check("reset_flush", {31'd0, out_valid}, 32'd0);
        tick();
        reset = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        check("reset_readdata", avl_readdata, 32'd0);
        repeat (6) tick();
        check("no_stale_output", {31'd0, out_valid}, 32'd0);
        rd_check("reset_gain0", 5'h08, 32'h10);
        rd_check("reset_ctrl", 5'h00, 32'h3);
        rd_check("reset_status", 5'h03, 32'h0);
        rd_check("reset_scnt", 5'h04, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
